cpu7_csr_access: RTL and testbench
==================================

# cpu7_csr_access

CSR instruction sequencer for the cpu7 core: accepts one decoded csrrd/csrwr/csrxchg at a time from the execute stage, drives the CSR file's read and write ports in separate cycles (read-modify-write for csrxchg), and returns the old CSR value with its destination-register tag to writeback. It is the initiator side of the `csr_raddr/csr_rdata/csr_waddr/csr_wdata/csr_wen` interface. An exception flush aborts any access that has not yet written.

## Interface
Parameters:
- `GRLEN`, 32, data width of CSRs and GPRs
- `CSR_BIT`, 14, CSR address width
- `TAG_W`, 5, destination-register tag width

Ports:
- `clk`  in  1  core clock
- `reset`  in  1  one clock; reset is asynchronous and active-high
- `req_valid`  in  1  CSR request valid
- `req_ready`  out  1  sequencer can accept a request
- `req_op`  in  2  `2'b10` csrwr, `2'b11` csrxchg, `2'b0x` csrrd
- `req_addr`  in  CSR_BIT  CSR number
- `req_wval`  in  GRLEN  write value (rd contents)
- `req_mask`  in  GRLEN  csrxchg bit mask (rj contents)
- `req_tag`  in  TAG_W  destination register
- `resp_valid`  out  1  old CSR value available
- `resp_ready`  in  1  writeback accepts response
- `resp_data`  out  GRLEN  CSR value read before any write
- `resp_tag`  out  TAG_W  latched `req_tag`
- `csr_raddr`  out  CSR_BIT  CSR file read address
- `csr_rdata`  in  GRLEN  CSR file read data (combinational from `csr_raddr`)
- `csr_waddr`  out  CSR_BIT  CSR file write address
- `csr_wdata`  out  GRLEN  CSR file write data
- `csr_wen`  out  1  CSR file write enable
- `flush`  in  1  exception/ertn flush; kills in-flight access
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, RD, WR, RSP.
- IDLE: `req_ready = ~flush`. Handshake (`req_valid & req_ready`) latches op, addr, wval, mask, tag; -> RD.
- RD: `csr_raddr` = latched addr; `csr_rdata` captured into `old` register at clock edge. op[1]=0 -> RSP; op[1]=1 -> WR.
- WR: `csr_wen = ~flush`; `csr_waddr` = latched addr; `csr_wdata` = wval for csrwr, `(wval & mask) | (old & ~mask)` for csrxchg; -> RSP.
- RSP: `resp_valid = 1`, `resp_data = old`, `resp_tag` = latched tag; held stable until `resp_ready`; then -> IDLE.
- `csr_raddr`/`csr_waddr` always show latched addr (stable outside RD/WR); `csr_wen` asserted only in WR.
- `csr_wdata` is combinational from latched/old registers; value outside WR irrelevant but deterministic.
- Flush: in RD or WR -> IDLE next edge, no write issued (wen gated same cycle), no response. In RSP -> response dropped, IDLE next edge; write already performed in WR is not undone. Flush in IDLE blocks acceptance.
- `resp_valid` and `req_ready` never asserted in the same cycle.

## Timing
- Cycle 0 accept; cycle 1 RD; csrrd: cycle 2 `resp_valid`; csrwr/csrxchg: cycle 2 write (CSR updated at end of cycle 2), cycle 3 `resp_valid`.
- Minimum spacing between accepts: 3 cycles (csrrd), 4 cycles (write ops), plus any `resp_ready` stall cycles.
- No combinational path from `req_*` to `csr_*` or `resp_*`; only `req_ready` depends combinationally on `flush`, `csr_wen` on `flush`.
- Reset (async, any state): state IDLE, `resp_valid`=0, `csr_wen`=0 immediately, `busy`=0, latched addr/wval/mask/tag/old = 0 (so `csr_raddr`=`csr_waddr`=0, `resp_data`=0, `resp_tag`=0, `csr_wdata`=0); `req_ready`=1 once reset deasserts with `flush`=0.

## Test plan
- csrrd addr 0x0 (CRMD=0x7), tag 4 -> `csr_raddr`=0x0 in cycle 1, no `csr_wen`, cycle 2 `resp_valid`, `resp_data`=0x7, `resp_tag`=4.
- csrwr addr 0xc, wval 0x1C000000, EENTRY old 0x0 -> cycle 2 `csr_wen`=1, `csr_wdata`=0x1C000000; cycle 3 `resp_data`=0x0; subsequent csrrd 0xc returns 0x1C000000.
- csrxchg addr 0x1, old 0x5, wval 0x2, mask 0x3 -> `csr_wdata`=0x6, `resp_data`=0x5.
- csrwr with `flush` asserted in the WR cycle -> `csr_wen` stays 0, no `resp_valid`, `busy` 0 next cycle, CSR unchanged.
- `resp_ready`=0 for 3 cycles in RSP -> `resp_valid`, `resp_data`, `resp_tag` stable, `req_ready`=0; new request accepted only the cycle after `resp_ready`=1.
- `reset` pulsed asynchronously mid-WR -> `csr_wen` drops before next edge, all outputs at reset values, next request completes normally.

Source files
------------

// File: rtl/cpu7_csr_access.sv
// ---------------------------------------------------------------------------
// cpu7_csr_access
//
// CSR instruction sequencer for the cpu7 core. Takes one decoded csrrd,
// csrwr or csrxchg at a time from execute and drives the CSR file's read
// and write ports in separate cycles. csrxchg is a read-modify-write. The
// old CSR value goes back to writeback with the destination-register tag.
// An exception/ertn flush aborts any access that has not written yet.
//
// Ports:
//   clk, reset           core clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake from execute
//   req_op               2'b10 csrwr, 2'b11 csrxchg, 2'b0x csrrd
//   req_addr             CSR number
//   req_wval             write value (rd contents)
//   req_mask             csrxchg bit mask (rj contents)
//   req_tag              destination register tag
//   resp_valid/ready     response handshake to writeback
//   resp_data            CSR value read before any write
//   resp_tag             latched request tag
//   csr_raddr/rdata      CSR file read port (rdata combinational)
//   csr_waddr/wdata/wen  CSR file write port
//   flush                kills the in-flight access
//   busy                 sequencer is not idle
// ---------------------------------------------------------------------------
module cpu7_csr_access #(
    parameter int GRLEN   = 32,
    parameter int CSR_BIT = 14,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [CSR_BIT-1:0] req_addr,
    input  logic [GRLEN-1:0]   req_wval,
    input  logic [GRLEN-1:0]   req_mask,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [GRLEN-1:0]   resp_data,
    output logic [TAG_W-1:0]   resp_tag,
    output logic [CSR_BIT-1:0] csr_raddr,
    input  logic [GRLEN-1:0]   csr_rdata,
    output logic [CSR_BIT-1:0] csr_waddr,
    output logic [GRLEN-1:0]   csr_wdata,
    output logic               csr_wen,
    input  logic               flush,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CSR_BIT-1:0] addr_q, addr_d;
    logic [GRLEN-1:0]   wval_q, wval_d;
    logic [GRLEN-1:0]   mask_q, mask_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [GRLEN-1:0]   old_q, old_d;
    logic               accept;

    // State and request/old-value registers. Reset clears everything so the
    // address, data and tag outputs all come up as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wval_q  <= '0;
            mask_q  <= '0;
            tag_q   <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wval_q  <= wval_d;
            mask_q  <= mask_d;
            tag_q   <= tag_d;
            old_q   <= old_d;
        end
    end

    // Next-state logic. A flush in any busy state returns to IDLE; in RSP it
    // drops the pending response even if writeback is ready this cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = S_RD;
            S_RD: begin
                if (flush)        state_d = S_IDLE;
                else if (op_q[1]) state_d = S_WR;
                else              state_d = S_RSP;
            end
            S_WR: begin
                if (flush) state_d = S_IDLE;
                else       state_d = S_RSP;
            end
            S_RSP: begin
                if (flush || resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: request fields are captured only on a handshake,
    // and the old value only in RD, so everything stays stable while the
    // response waits for writeback.
    always_comb begin
        op_d   = op_q;
        addr_d = addr_q;
        wval_d = wval_q;
        mask_d = mask_q;
        tag_d  = tag_q;
        old_d  = old_q;
        if (accept) begin
            op_d   = req_op;
            addr_d = req_addr;
            wval_d = req_wval;
            mask_d = req_mask;
            tag_d  = req_tag;
        end
        if (state_q == S_RD) begin
            old_d = csr_rdata;
        end
    end

    // Handshake and strobe outputs. Only req_ready and csr_wen look at flush
    // combinationally, so a flush in the write cycle suppresses the write.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        csr_wen    = 1'b0;
        busy       = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE:  req_ready  = ~flush;
            S_WR:    csr_wen    = ~flush;
            S_RSP:   resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept    = req_valid & req_ready;
    assign csr_raddr = addr_q;
    assign csr_waddr = addr_q;
    assign resp_data = old_q;
    assign resp_tag  = tag_q;

    // csrxchg merges only the masked bits of wval into the old value; every
    // other write op replaces the whole CSR.
    assign csr_wdata = op_q[0] ? ((wval_q & mask_q) | (old_q & ~mask_q)) : wval_q;

endmodule

// File: tb/tb_cpu7_csr_access.sv
// ---------------------------------------------------------------------------
// tb_cpu7_csr_access
//
// Directed bench for cpu7_csr_access. A small CSR file model answers the
// read port and takes writes; a separate reference copy of the CSR contents
// predicts old values and write data. Expected responses are pushed to a
// scoreboard queue on acceptance and popped when the response handshakes.
// ---------------------------------------------------------------------------
module tb_cpu7_csr_access;

    localparam int GRLEN   = 32;
    localparam int CSR_BIT = 14;
    localparam int TAG_W   = 5;

    logic               clk;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [CSR_BIT-1:0] req_addr;
    logic [GRLEN-1:0]   req_wval;
    logic [GRLEN-1:0]   req_mask;
    logic [TAG_W-1:0]   req_tag;
    logic               resp_valid;
    logic               resp_ready;
    logic [GRLEN-1:0]   resp_data;
    logic [TAG_W-1:0]   resp_tag;
    logic [CSR_BIT-1:0] csr_raddr;
    logic [GRLEN-1:0]   csr_rdata;
    logic [CSR_BIT-1:0] csr_waddr;
    logic [GRLEN-1:0]   csr_wdata;
    logic               csr_wen;
    logic               flush;
    logic               busy;

    logic               mem_load;
    logic [GRLEN-1:0]   csr_mem [0:63];
    logic [GRLEN-1:0]   ref_csr [0:63];
    logic [GRLEN+TAG_W-1:0] sb_q [$];

    int num_checks;
    int num_errors;

    cpu7_csr_access #(
        .GRLEN  (GRLEN),
        .CSR_BIT(CSR_BIT),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wval  (req_wval),
        .req_mask  (req_mask),
        .req_tag   (req_tag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_tag  (resp_tag),
        .csr_raddr (csr_raddr),
        .csr_rdata (csr_rdata),
        .csr_waddr (csr_waddr),
        .csr_wdata (csr_wdata),
        .csr_wen   (csr_wen),
        .flush     (flush),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR file model: combinational read, write on the clock edge.
    assign csr_rdata = csr_mem[csr_raddr[5:0]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) begin
                csr_mem[i] <= (i == 0) ? 32'h7 : ((i == 1) ? 32'h5 : 32'h0);
            end
        end else if (csr_wen) begin
            csr_mem[csr_waddr[5:0]] <= csr_wdata;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        num_checks++;
        assert (obs === exp) else begin
            num_errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Runs one request from acceptance to the end of its response.
    // kill: 0 normal, 1 flush during WR, 2 asynchronous reset pulse during WR.
    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [CSR_BIT-1:0] addr,
                                 input logic [GRLEN-1:0] wval, input logic [GRLEN-1:0] mask,
                                 input logic [TAG_W-1:0] tag, input int stall, input int kill);
        logic [GRLEN-1:0]       old_v;
        logic [GRLEN-1:0]       new_v;
        logic [GRLEN+TAG_W-1:0] item;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wval  = wval;
        req_mask  = mask;
        req_tag   = tag;
        old_v = ref_csr[addr[5:0]];
        new_v = (op == 2'b11) ? ((wval & mask) | (old_v & ~mask)) : wval;
        @(negedge clk);
        checkOutput("accept_req_ready", req_ready, 1);
        if (kill == 0) sb_q.push_back({old_v, tag});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = CSR_BIT'($urandom);
        req_wval  = $urandom;
        req_mask  = $urandom;
        req_tag   = TAG_W'($urandom);
        @(negedge clk);
        checkOutput("rd_raddr", csr_raddr, addr);
        checkOutput("rd_wen", csr_wen, 0);
        checkOutput("rd_busy", busy, 1);
        checkOutput("rd_req_ready", req_ready, 0);
        @(posedge clk); #1;
        if (op[1]) begin
            if (kill == 1) flush = 1'b1;
            @(negedge clk);
            if (kill == 2) begin
                checkOutput("wr_wen_pre_reset", csr_wen, 1);
                reset = 1'b1;
                #1;
                checkOutput("rst_wen", csr_wen, 0);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_resp_valid", resp_valid, 0);
                checkOutput("rst_raddr", csr_raddr, 0);
                checkOutput("rst_waddr", csr_waddr, 0);
                checkOutput("rst_wdata", csr_wdata, 0);
                checkOutput("rst_resp_data", resp_data, 0);
                checkOutput("rst_resp_tag", resp_tag, 0);
                #1;
                reset = 1'b0;
            end else if (kill == 1) begin
                checkOutput("flush_wen", csr_wen, 0);
                checkOutput("flush_req_ready", req_ready, 0);
            end else begin
                checkOutput("wr_wen", csr_wen, 1);
                checkOutput("wr_waddr", csr_waddr, addr);
                checkOutput("wr_wdata", csr_wdata, new_v);
                ref_csr[addr[5:0]] = new_v;
            end
            @(posedge clk); #1;
            flush = 1'b0;
            if (kill != 0) begin
                @(negedge clk);
                checkOutput("kill_busy", busy, 0);
                checkOutput("kill_resp_valid", resp_valid, 0);
                checkOutput("kill_csr_unchanged", csr_mem[addr[5:0]], old_v);
                checkOutput("kill_req_ready", req_ready, 1);
                @(posedge clk); #1;
                return;
            end
        end
        if (stall > 0) resp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_resp_valid", resp_valid, 1);
            checkOutput("stall_req_ready", req_ready, 0);
            checkOutput("stall_resp_data", resp_data, sb_q[0][GRLEN+TAG_W-1:TAG_W]);
            checkOutput("stall_resp_tag", resp_tag, sb_q[0][TAG_W-1:0]);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("rsp_valid", resp_valid, 1);
        checkOutput("rsp_req_ready", req_ready, 0);
        checkOutput("rsp_sb_nonempty", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            checkOutput("rsp_data", resp_data, item[GRLEN+TAG_W-1:TAG_W]);
            checkOutput("rsp_tag", resp_tag, item[TAG_W-1:0]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_resp_valid", resp_valid, 0);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_req_ready", req_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        num_checks = 0;
        num_errors = 0;
        reset      = 1'b1;
        mem_load   = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr   = '0;
        req_wval   = '0;
        req_mask   = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        flush      = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ref_csr[i] = (i == 0) ? 32'h7 : ((i == 1) ? 32'h5 : 32'h0);
        end

        #1;
        checkOutput("reset_resp_valid", resp_valid, 0);
        checkOutput("reset_wen", csr_wen, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_raddr", csr_raddr, 0);
        checkOutput("reset_wdata", csr_wdata, 0);
        checkOutput("reset_resp_tag", resp_tag, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset    = 1'b0;
        mem_load = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);
        @(posedge clk); #1;

        $display("[TB] csrrd CRMD");
        applyStimulus(2'b00, 14'h0, 32'h0, 32'h0, 5'd4, 0, 0);
        $display("[TB] csrwr EENTRY");
        applyStimulus(2'b10, 14'hc, 32'h1C000000, 32'h0, 5'd7, 0, 0);
        checkOutput("eentry_written", csr_mem[12], 32'h1C000000);
        $display("[TB] csrrd EENTRY");
        applyStimulus(2'b01, 14'hc, 32'h0, 32'h0, 5'd9, 0, 0);
        $display("[TB] csrxchg addr 1");
        applyStimulus(2'b11, 14'h1, 32'h2, 32'h3, 5'd3, 0, 0);
        checkOutput("xchg_written", csr_mem[1], 32'h6);
        $display("[TB] csrwr killed by flush in WR");
        applyStimulus(2'b10, 14'h20, 32'hDEAD, 32'h0, 5'd1, 0, 1);
        applyStimulus(2'b00, 14'h20, 32'h0, 32'h0, 5'd2, 0, 0);
        $display("[TB] csrrd with writeback stall");
        applyStimulus(2'b00, 14'h1, 32'h0, 32'h0, 5'd17, 3, 0);

        $display("[TB] flush in IDLE");
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_addr  = 14'h1;
        @(negedge clk);
        checkOutput("idle_flush_req_ready", req_ready, 0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle_flush_busy", busy, 0);
        @(posedge clk); #1;

        $display("[TB] csrwr killed by reset in WR");
        applyStimulus(2'b10, 14'h30, 32'hCAFE_F00D, 32'h0, 5'd5, 0, 2);
        applyStimulus(2'b11, 14'h30, 32'hFFFF0000, 32'h0F0F0F0F, 5'd31, 0, 0);
        applyStimulus(2'b00, 14'h30, 32'h0, 32'h0, 5'd30, 1, 0);
        checkOutput("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
        $finish;
    end

endmodule
